win3x3_fetch: RTL and testbench

Read-side initiator for the 3-word-wide line memory of the 3x3 blur datapath. Walks every valid 3x3 window of a frame in raster order and drives ADDR/RD into the memory. Collects the three 3-pixel row slices into one 9-pixel window and presents it downstream on a valid/ready handshake. It sits between the frame memory and the blur kernel.

---
 rtl/win3x3_fetch.sv | 170 +++++++++++++++++
 tb/tb_win3x3_fetch.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win3x3_fetch.sv
// ---------------------------------------------------------------------------
// win3x3_fetch
//
// Read-side initiator for the 3-word-wide line memory that feeds the 3x3 blur
// kernel. Walks every valid 3x3 window of an img_w x img_h frame in raster
// order. For each window it issues three row reads, then gathers the three
// 3-pixel row slices into one 9-pixel window. The window is presented
// downstream on a valid/ready handshake.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset (aborts a frame, no DONE)
//   START      frame start request, only sampled while idle
//   BUSY       high while a frame is in progress
//   DONE       one-cycle pulse after the last window of a frame is accepted
//   MEM_ADDR   row-slice start address of the current read
//   MEM_RD     memory read enable (read data returns one cycle later)
//   MEM_ODATA  memory read data, lane c = mem[MEM_ADDR + c]
//   WIN_DATA   window, pixel(r,c) at [(3r+c)*data_w +: data_w]
//   WIN_X      window top-left column
//   WIN_Y      window top-left row
//   WIN_VALID  window available
//   WIN_READY  downstream accepts the window
//
// Per window: 3 ISSUE cycles + 1 FLUSH cycle + >=1 OUT cycle, so one window
// every 5 cycles when WIN_READY is tied high.
// ---------------------------------------------------------------------------
module win3x3_fetch #(
    parameter int addr_w = 8,
    parameter int data_w = 8,
    parameter int img_w  = 16,
    parameter int img_h  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [addr_w-1:0]     MEM_ADDR,
    output logic                  MEM_RD,
    input  logic [3*data_w-1:0]   MEM_ODATA,
    output logic [9*data_w-1:0]   WIN_DATA,
    output logic [addr_w-1:0]     WIN_X,
    output logic [addr_w-1:0]     WIN_Y,
    output logic                  WIN_VALID,
    input  logic                  WIN_READY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    // Address step between vertically adjacent pixels.
    localparam logic [addr_w-1:0] ROW_STEP = addr_w'(img_w);
    // Last legal top-left column / row of a window.
    localparam logic [addr_w-1:0] X_LAST   = addr_w'(img_w - 3);
    localparam logic [addr_w-1:0] Y_LAST   = addr_w'(img_h - 3);

    logic [1:0]        state;
    logic [1:0]        row_cnt;    // row of the window being read (0..2)
    logic [addr_w-1:0] base_addr;  // address of the window's top-left pixel

    // Delayed copy of the read request: tells the capture stage which window
    // row the data currently on MEM_ODATA belongs to.
    logic              cap_vld_p0;
    logic [1:0]        cap_row_p0;

    // ---- stage 0: read issue and window sequencing ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            row_cnt    <= 2'd0;
            base_addr  <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_RD     <= 1'b0;
            WIN_X      <= '0;
            WIN_Y      <= '0;
            WIN_VALID  <= 1'b0;
            cap_vld_p0 <= 1'b0;
            cap_row_p0 <= 2'd0;
        end else begin
            DONE       <= 1'b0;
            cap_vld_p0 <= MEM_RD;
            cap_row_p0 <= row_cnt;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state     <= S_ISSUE;
                        row_cnt   <= 2'd0;
                        base_addr <= '0;
                        WIN_X     <= '0;
                        WIN_Y     <= '0;
                        MEM_ADDR  <= '0;
                        MEM_RD    <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (row_cnt == 2'd2) begin
                        state  <= S_FLUSH;
                        MEM_RD <= 1'b0;
                    end else begin
                        row_cnt  <= row_cnt + 2'd1;
                        MEM_ADDR <= MEM_ADDR + ROW_STEP;
                    end
                end

                S_FLUSH: begin
                    // Row 2 lands in the capture stage at this edge.
                    state     <= S_OUT;
                    WIN_VALID <= 1'b1;
                end

                S_OUT: begin
                    if (WIN_READY) begin
                        WIN_VALID <= 1'b0;
                        if (WIN_X < X_LAST) begin
                            state     <= S_ISSUE;
                            row_cnt   <= 2'd0;
                            WIN_X     <= WIN_X + addr_w'(1);
                            base_addr <= base_addr + addr_w'(1);
                            MEM_ADDR  <= base_addr + addr_w'(1);
                            MEM_RD    <= 1'b1;
                        end else if (WIN_Y < Y_LAST) begin
                            // base_addr is y*img_w + (img_w-3); adding 3 lands
                            // on the first pixel of the next row.
                            state     <= S_ISSUE;
                            row_cnt   <= 2'd0;
                            WIN_X     <= '0;
                            WIN_Y     <= WIN_Y + addr_w'(1);
                            base_addr <= base_addr + addr_w'(3);
                            MEM_ADDR  <= base_addr + addr_w'(3);
                            MEM_RD    <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- stage 1: capture returning row slice into the window ----
    // Lane c of the memory word is column c of the slice, so a whole row
    // drops straight into its 3-pixel field of the window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WIN_DATA <= '0;
        end else if (cap_vld_p0) begin
            case (cap_row_p0)
                2'd0:    WIN_DATA[0*3*data_w +: 3*data_w] <= MEM_ODATA;
                2'd1:    WIN_DATA[1*3*data_w +: 3*data_w] <= MEM_ODATA;
                2'd2:    WIN_DATA[2*3*data_w +: 3*data_w] <= MEM_ODATA;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_win3x3_fetch.sv
module tb_win3x3_fetch;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int IH = 16;

    logic              CLK       = 1'b0;
    logic              RST_N     = 1'b0;
    logic              START     = 1'b0;
    logic              WIN_READY = 1'b0;
    logic              BUSY;
    logic              DONE;
    logic [AW-1:0]     MEM_ADDR;
    logic              MEM_RD;
    logic [3*DW-1:0]   MEM_ODATA;
    logic [9*DW-1:0]   WIN_DATA;
    logic [AW-1:0]     WIN_X;
    logic [AW-1:0]     WIN_Y;
    logic              WIN_VALID;

    int checks = 0;
    int errors = 0;
    int now_cyc = 0;

    // written only by the monitor
    int            done_cnt  = 0;
    int            rd_in_out = 0;
    logic [AW-1:0] max_addr  = '0;

    logic [7:0] mem [0:255];

    win3x3_fetch #(.addr_w(AW), .data_w(DW), .img_w(IW), .img_h(IH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_RD    (MEM_RD),
        .MEM_ODATA (MEM_ODATA),
        .WIN_DATA  (WIN_DATA),
        .WIN_X     (WIN_X),
        .WIN_Y     (WIN_Y),
        .WIN_VALID (WIN_VALID),
        .WIN_READY (WIN_READY)
    );

    always #5 CLK = ~CLK;

    // one-cycle read latency memory model
    always @(posedge CLK) begin
        if (MEM_RD)
            MEM_ODATA <= {mem[MEM_ADDR + 8'd2], mem[MEM_ADDR + 8'd1], mem[MEM_ADDR]};
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            if (DONE) done_cnt = done_cnt + 1;
            if (MEM_RD && WIN_VALID) rd_in_out = rd_in_out + 1;
            if (MEM_RD && MEM_ADDR > max_addr) max_addr = MEM_ADDR;
        end
    end

    function automatic logic [9*DW-1:0] exp_win(input int x, input int y);
        logic [9*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*DW +: DW] = DW'((y + r) * IW + x + c);
        return w;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        now_cyc = now_cyc + 1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        WIN_READY = 1'b1;
        repeat (3) step();
        checks++;
        if ({BUSY, DONE, MEM_RD, WIN_VALID} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b rd=%b valid=%b, required all 0",
                     BUSY, DONE, MEM_RD, WIN_VALID);
        end
        checks++;
        if (MEM_ADDR !== '0 || WIN_X !== '0 || WIN_Y !== '0 || WIN_DATA !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d x=%0d y=%0d data=%h, required all 0",
                     MEM_ADDR, WIN_X, WIN_Y, WIN_DATA);
        end
        RST_N = 1'b1;
        repeat (2) step();
        checks++;
        if (BUSY !== 1'b0 || MEM_RD !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b rd=%b, required 0 0", BUSY, MEM_RD);
        end
    endtask

    task automatic test_first_window();
        logic [AW-1:0] exp_addr [0:2];
        exp_addr[0] = 8'd0;
        exp_addr[1] = 8'd16;
        exp_addr[2] = 8'd32;
        START = 1'b1;
        step();
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b, required 1", BUSY);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (MEM_RD !== 1'b1 || MEM_ADDR !== exp_addr[i]) begin
                errors++;
                $display("FAIL first_read%0d: rd=%b addr=%0d, required rd=1 addr=%0d",
                         i, MEM_RD, MEM_ADDR, exp_addr[i]);
            end
        end
        step();
        checks++;
        if (MEM_RD !== 1'b0 || WIN_VALID !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: rd=%b valid=%b, required 0 0", MEM_RD, WIN_VALID);
        end
        step();
        checks++;
        if (WIN_VALID !== 1'b1 || WIN_X !== 8'd0 || WIN_Y !== 8'd0) begin
            errors++;
            $display("FAIL first_valid: valid=%b x=%0d y=%0d, required 1 0 0",
                     WIN_VALID, WIN_X, WIN_Y);
        end
        checks++;
        if (WIN_DATA !== 72'h222120121110020100) begin
            errors++;
            $display("FAIL first_data: got %h, required 222120121110020100", WIN_DATA);
        end
    endtask

    task automatic test_backpressure();
        logic [9*DW-1:0] d;
        logic [AW-1:0]   x;
        logic [AW-1:0]   y;
        d = WIN_DATA;
        x = WIN_X;
        y = WIN_Y;
        WIN_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (WIN_VALID !== 1'b1 || MEM_RD !== 1'b0) begin
                errors++;
                $display("FAIL bp_ctrl cyc%0d: valid=%b rd=%b, required valid=1 rd=0",
                         i, WIN_VALID, MEM_RD);
            end
            checks++;
            if (WIN_DATA !== d || WIN_X !== x || WIN_Y !== y) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: x=%0d y=%0d data=%h, required x=%0d y=%0d data=%h",
                         i, WIN_X, WIN_Y, WIN_DATA, x, y, d);
            end
        end
        WIN_READY = 1'b1;
    endtask

    // Starts at the cycle where window (0,0) is valid; runs the whole frame,
    // holding START high from mid-frame through the DONE cycle.
    task automatic test_full_frame();
        int hs;
        int ex;
        int ey;
        bit bp_done;
        logic [9*DW-1:0] last_data;
        hs = 0;
        ex = 0;
        ey = 0;
        bp_done = 1'b0;
        last_data = '0;
        WIN_READY = 1'b1;
        for (int cyc = 0; cyc < 3000 && hs < 196; cyc++) begin
            if (hs == 50) START = 1'b1;
            if (WIN_VALID) begin
                if (!bp_done && WIN_X == 8'd5 && WIN_Y == 8'd3) begin
                    test_backpressure();
                    bp_done = 1'b1;
                end
                checks++;
                if (WIN_X !== AW'(ex) || WIN_Y !== AW'(ey)) begin
                    errors++;
                    $display("FAIL order hs%0d: x=%0d y=%0d, required x=%0d y=%0d",
                             hs, WIN_X, WIN_Y, ex, ey);
                end
                checks++;
                if (WIN_DATA !== exp_win(ex, ey)) begin
                    errors++;
                    $display("FAIL win_data (%0d,%0d): got %h, required %h",
                             ex, ey, WIN_DATA, exp_win(ex, ey));
                end
                if (hs == 195) begin
                    checks++;
                    if (BUSY !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_before_last: busy=%b, required 1", BUSY);
                    end
                end
                last_data = WIN_DATA;
                hs++;
                if (ex < IW - 3) ex++;
                else begin
                    ex = 0;
                    ey++;
                end
            end
            step();
        end
        checks++;
        if (hs != 196) begin
            errors++;
            $display("FAIL handshake_count: got %0d, required 196", hs);
        end
        checks++;
        if (bp_done != 1'b1) begin
            errors++;
            $display("FAIL bp_reached: window (5,3) seen=%0d, required 1", bp_done);
        end
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b busy=%b, required done=1 busy=0", DONE, BUSY);
        end
        checks++;
        if (last_data !== 72'hFFFEFDEFEEEDDFDEDD) begin
            errors++;
            $display("FAIL last_data: got %h, required fffefdefeeeddfdedd", last_data);
        end
        checks++;
        if (max_addr !== 8'd253) begin
            errors++;
            $display("FAIL max_addr: got %0d, required 253", max_addr);
        end
        checks++;
        if (rd_in_out != 0) begin
            errors++;
            $display("FAIL rd_during_out: got %0d cycles, required 0", rd_in_out);
        end
        // START still high in the DONE cycle: a second frame begins here.
        step();
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0 || MEM_RD !== 1'b1 || MEM_ADDR !== 8'd0) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b rd=%b addr=%0d, required 1 0 1 0",
                     BUSY, DONE, MEM_RD, MEM_ADDR);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d, required 1", done_cnt);
        end
    endtask

    // Entered one cycle after the edge that started the second frame.
    task automatic test_throughput();
        int t_prev;
        int waited;
        t_prev = 0;
        WIN_READY = 1'b1;
        for (int n = 0; n < 8; n++) begin
            waited = 0;
            while (!WIN_VALID && waited < 20) begin
                step();
                waited++;
            end
            checks++;
            if (WIN_VALID !== 1'b1) begin
                errors++;
                $display("FAIL tp_timeout win%0d: valid=%b, required 1", n, WIN_VALID);
            end
            checks++;
            if (n == 0 && waited != 4) begin
                errors++;
                $display("FAIL tp_latency: got %0d cycles, required 4", waited);
            end else if (n > 0 && now_cyc - t_prev != 5) begin
                errors++;
                $display("FAIL tp_spacing win%0d: got %0d cycles, required 5",
                         n, now_cyc - t_prev);
            end
            t_prev = now_cyc;
            step();
            checks++;
            if (WIN_VALID !== 1'b0) begin
                errors++;
                $display("FAIL tp_width win%0d: valid=%b after 1 cycle, required 0",
                         n, WIN_VALID);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int waited;
        int d0;
        waited = 0;
        while (!(WIN_X == 8'd7 && WIN_Y == 8'd2 && MEM_RD) && waited < 400) begin
            step();
            waited++;
        end
        checks++;
        if (!(WIN_X == 8'd7 && WIN_Y == 8'd2 && MEM_RD)) begin
            errors++;
            $display("FAIL reach_7_2: x=%0d y=%0d rd=%b, required 7 2 1", WIN_X, WIN_Y, MEM_RD);
        end
        d0 = done_cnt;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, MEM_RD, WIN_VALID} !== 4'b0000 || MEM_ADDR !== '0 ||
            WIN_X !== '0 || WIN_Y !== '0 || WIN_DATA !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b rd=%b valid=%b addr=%0d x=%0d y=%0d data=%h, required all 0",
                     BUSY, DONE, MEM_RD, WIN_VALID, MEM_ADDR, WIN_X, WIN_Y, WIN_DATA);
        end
        repeat (2) step();
        RST_N = 1'b1;
        repeat (2) step();
        checks++;
        if (done_cnt != d0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: pulses=%0d done=%b busy=%b, required %0d 0 0",
                     done_cnt, DONE, BUSY, d0);
        end
        START = 1'b1;
        step();
        START = 1'b0;
        checks++;
        if (MEM_RD !== 1'b1 || MEM_ADDR !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_start: rd=%b addr=%0d, required 1 0", MEM_RD, MEM_ADDR);
        end
        repeat (4) step();
        checks++;
        if (WIN_VALID !== 1'b1 || WIN_X !== 8'd0 || WIN_Y !== 8'd0 ||
            WIN_DATA !== exp_win(0, 0)) begin
            errors++;
            $display("FAIL post_reset_win: valid=%b x=%0d y=%0d data=%h, required 1 0 0 %h",
                     WIN_VALID, WIN_X, WIN_Y, WIN_DATA, exp_win(0, 0));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset();
        test_first_window();
        test_full_frame();
        test_throughput();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
